// File: rtl/bnn_pkg.sv
// Shared types and constants for the 7x7 binary XNOR-popcount window sequencer.
package bnn_pkg;
  localparam int K       = 7;
  localparam int KK      = K * K;
  localparam int POP_W   = 6;
  localparam int ROW_W   = 3;
  localparam int SCORE_W = 7;
  localparam logic [SCORE_W-1:0] SCORE_BIAS = 7'd49;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_e;

  // Signed +/-1 dot product from a match count: 2*pop - 49 in 7-bit arithmetic.
  function automatic logic [SCORE_W-1:0] to_score(input logic [POP_W-1:0] acc);
    return {acc, 1'b0} - SCORE_BIAS;
  endfunction
endpackage

// File: rtl/xnor_pop_row.sv
// One kernel row of the binary datapath: bitwise XNOR then population count.
module xnor_pop_row
  import bnn_pkg::*;
#(
  parameter int N     = K,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     img_i,
  input  logic [N-1:0]     w_i,
  output logic [CNT_W-1:0] pop_o
);
  logic [N-1:0] match;

  always_comb begin
    match = ~(img_i ^ w_i);
    pop_o = '0;
    for (int i = 0; i < N; i++) pop_o = pop_o + CNT_W'(match[i]);
  end
endmodule

// File: rtl/bnn_window_sched.sv
// Kernel holder and row-serial XNOR/popcount sequencer for 7x7 binary windows.
// Optional thresholded activation output is built when BNN_THRESH_EN is defined.
module bnn_window_sched #(
  parameter int K        = bnn_pkg::K,
  parameter int THRESH_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                w_valid,
  input  logic [K-1:0]        w_row,
  output logic                w_ready,
  input  logic                in_valid,
  input  logic [K*K-1:0]      in_img,
  output logic                in_ready,
  input  logic [THRESH_W-1:0] thresh,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [5:0]          out_pop,
  output logic [6:0]          out_score,
  output logic                out_act,
  output bnn_pkg::state_e     dbg_state_o
);
  import bnn_pkg::*;

  localparam int CNT_W = $clog2(K + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(K - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and out_valid holds its data until taken.
  state_e               state_q, state_d;
  logic [ROW_W-1:0]     w_ptr_q, w_ptr_d, row_q, row_d;
  logic [POP_W-1:0]     acc_q, acc_d, acc_sum;
  logic                 w_loaded_q, w_loaded_d;
  logic [K*K-1:0]       img_q, img_d;
  logic                 out_valid_q, out_valid_d, out_act_q, out_act_d;
  logic [POP_W-1:0]     out_pop_q, out_pop_d;
  logic [SCORE_W-1:0]   out_score_q, out_score_d, score_next;
  logic                 act_next, w_accept, in_accept;
  logic [K-1:0]         kernel_q [K];
  logic [K-1:0]         img_rows [K];
  logic [CNT_W-1:0]     row_pop;

  assign w_ready     = (state_q == IDLE);
  assign in_ready    = (state_q == IDLE) && w_loaded_q && !w_valid;
  assign w_accept    = w_valid && w_ready && !flush;
  assign in_accept   = in_valid && in_ready && !flush;
  assign out_valid   = out_valid_q;
  assign out_pop     = out_pop_q;
  assign out_score   = out_score_q;
  assign out_act     = out_act_q;
  assign dbg_state_o = state_q;

  for (genvar r = 0; r < K; r++) begin : g_rows
    assign img_rows[r] = img_q[r*K +: K];
  end

  xnor_pop_row #(.N(K), .CNT_W(CNT_W)) u_row (
    .img_i (img_rows[row_q]),
    .w_i   (kernel_q[row_q]),
    .pop_o (row_pop)
  );

  assign acc_sum    = acc_q + POP_W'(row_pop);
  assign score_next = to_score(acc_sum);

`ifdef BNN_THRESH_EN
  logic [THRESH_W-1:0] thresh_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           thresh_q <= '0;
    else if (in_accept) thresh_q <= thresh;
  end

  assign act_next = $signed(score_next) >= $signed(thresh_q);
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign act_next      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    w_ptr_d     = w_ptr_q;
    row_d       = row_q;
    acc_d       = acc_q;
    w_loaded_d  = w_loaded_q;
    img_d       = img_q;
    out_valid_d = out_valid_q;
    out_pop_d   = out_pop_q;
    out_score_d = out_score_q;
    out_act_d   = out_act_q;
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      w_ptr_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            // Starting a new load invalidates the kernel until row K-1 lands.
            w_ptr_d = (w_ptr_q == ROW_LAST) ? '0 : w_ptr_q + 1'b1;
            if (w_ptr_q == ROW_LAST)  w_loaded_d = 1'b1;
            else if (w_ptr_q == '0)   w_loaded_d = 1'b0;
          end else if (in_accept) begin
            img_d   = in_img;
            acc_d   = '0;
            row_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          acc_d = acc_sum;
          row_d = row_q + 1'b1;
          if (row_q == ROW_LAST) begin
            row_d       = '0;
            state_d     = OUT;
            out_valid_d = 1'b1;
            out_pop_d   = acc_sum;
            out_score_d = score_next;
            out_act_d   = act_next;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      w_ptr_q     <= '0;
      row_q       <= '0;
      acc_q       <= '0;
      w_loaded_q  <= 1'b0;
      img_q       <= '0;
      out_valid_q <= 1'b0;
      out_pop_q   <= '0;
      out_score_q <= '0;
      out_act_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_ptr_q     <= w_ptr_d;
      row_q       <= row_d;
      acc_q       <= acc_d;
      w_loaded_q  <= w_loaded_d;
      img_q       <= img_d;
      out_valid_q <= out_valid_d;
      out_pop_q   <= out_pop_d;
      out_score_q <= out_score_d;
      out_act_q   <= out_act_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < K; r++) kernel_q[r] <= '0;
    end else if (w_accept) begin
      kernel_q[w_ptr_q] <= w_row;
    end
  end
endmodule

// File: tb/tb_bnn_window_sched.sv
// Directed bench for bnn_window_sched with a popcount reference model and result scoreboard.
module tb_bnn_window_sched;
  import bnn_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, w_valid, in_valid, out_ready;
  logic        w_ready, in_ready, out_valid, out_act;
  logic [6:0]  w_row, thresh, out_score;
  logic [48:0] in_img;
  logic [5:0]  out_pop;
  state_e      dbg_state;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          fail_cnt  = 0;
  logic [13:0] exp_q[$];
  logic [48:0] tb_kernel;

  always #5 clk = ~clk;

  bnn_window_sched dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .w_valid     (w_valid),
    .w_row       (w_row),
    .w_ready     (w_ready),
    .in_valid    (in_valid),
    .in_img      (in_img),
    .in_ready    (in_ready),
    .thresh      (thresh),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pop     (out_pop),
    .out_score   (out_score),
    .out_act     (out_act),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] model(input logic [48:0] k, input logic [48:0] img,
                                        input logic [6:0] th);
    int         pop, score;
    logic       act;
    pop   = $countones(~(img ^ k));
    score = 2 * pop - 49;
`ifdef BNN_THRESH_EN
    act = (score >= int'($signed(th)));
`else
    act = 1'b0;
    if (th === 7'bx) act = 1'b0;
`endif
    return {6'(pop), 7'(score), act};
  endfunction

  task automatic load_kernel(input logic [48:0] k);
    for (int r = 0; r < 7; r++) begin
      @(negedge clk);
      w_valid = 1'b1;
      w_row   = k[r*7 +: 7];
      @(posedge clk);
    end
    @(negedge clk);
    w_valid   = 1'b0;
    tb_kernel = k;
  endtask

  task automatic send_window(input logic [48:0] img, input logic [6:0] th);
    int n;
    @(negedge clk);
    in_img   = img;
    thresh   = th;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(model(tb_kernel, img, th));
    @(negedge clk);
    in_valid = 1'b0;
    in_img   = 49'({$urandom(), $urandom()});
    thresh   = 7'($urandom());
  endtask

  task automatic wait_result(input int exp_lat);
    int          n;
    logic [13:0] e;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
    if (!out_valid) return;
    if (exp_lat > 0) check("latency", 32'(n), 32'(exp_lat));
    check("sb_depth", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("out_pop", 32'(out_pop), 32'(e[13:8]));
    check("out_score", 32'(out_score), 32'(e[7:1]));
    check("out_act", 32'(out_act), 32'(e[0]));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("state_after_hs", 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [48:0] cb, img, k2;
    logic [13:0] snap, e;
    int          bad;

    rst = 1'b0; flush = 1'b0; w_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    w_row = '0; thresh = '0; in_img = '0; tb_kernel = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_w_ready", 32'(w_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_pop", 32'(out_pop), 32'd0);
    check("rst_out_score", 32'(out_score), 32'd0);
    check("rst_out_act", 32'(out_act), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;

    // All-ones kernel against all-ones and all-zeros windows.
    load_kernel({49{1'b1}});
    send_window({49{1'b1}}, 7'd0);
    wait_result(7);
    send_window('0, 7'd0);
    wait_result(7);

    // Checkerboard kernel, row 3 inverted: 42 matches, score 35, threshold edge.
    for (int i = 0; i < 49; i++) cb[i] = (i % 2 == 1);
    load_kernel(cb);
    img = cb ^ (49'h7F << 21);
    send_window(img, 7'd35);
    wait_result(7);
    send_window(img, 7'd36);
    wait_result(7);
    send_window(cb, 7'h4F);
    wait_result(7);

    // Simultaneous weight beat and window: weights win, reload blocks windows.
    k2 = 49'({$urandom(), $urandom()});
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      w_valid = 1'b1; w_row = k2[r*7 +: 7]; in_valid = 1'b1; in_img = cb;
      #1;
      check("simul_in_ready", 32'(in_ready), 32'd0);
      check("simul_w_ready", 32'(w_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    w_valid = 1'b0;
    bad = 0;
    repeat (4) begin
      #1;
      if (in_ready !== 1'b0 || dbg_state !== IDLE) bad++;
      @(negedge clk);
    end
    check("partial_load_block", 32'(bad), 32'd0);
    for (int r = 3; r < 7; r++) begin
      w_valid = 1'b1; w_row = k2[r*7 +: 7];
      @(posedge clk);
      @(negedge clk);
    end
    w_valid = 1'b0;
    #1;
    check("reload_in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b0;
    tb_kernel = k2;
    send_window(49'({$urandom(), $urandom()}), 7'($urandom_range(0, 127)));
    wait_result(7);

    // Back-pressure: hold the result for 20 cycles, then release into the next window.
    send_window(49'({$urandom(), $urandom()}), 7'($urandom_range(0, 127)));
    bad = 0;
    while (!out_valid && bad < 40) begin
      @(negedge clk);
      bad++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    snap = {out_pop, out_score, out_act};
    bad  = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || in_ready || {out_pop, out_score, out_act} !== snap) bad++;
    end
    check("bp_hold_stable", 32'(bad), 32'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 14'h3FFF;
    check("bp_result", 32'(snap), 32'(e));
    img       = 49'({$urandom(), $urandom()});
    in_img    = img;
    thresh    = 7'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_next_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(model(tb_kernel, img, 7'd0));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_calc", 32'(dbg_state), 32'(CALC));
    wait_result(7);

    // flush while row 4 is being processed.
    send_window(49'({$urandom(), $urandom()}), 7'd0);
    repeat (4) @(negedge clk);
    check("flush_pre_calc", 32'(dbg_state), 32'(CALC));
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_state", 32'(dbg_state), 32'(IDLE));
    check("flush_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("flush_no_out", 32'(bad), 32'd0);
    send_window(49'({$urandom(), $urandom()}), 7'($urandom_range(0, 127)));
    wait_result(7);

    // Reset pulse mid-CALC wipes the kernel and needs a reload.
    send_window(49'({$urandom(), $urandom()}), 7'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_state", 32'(dbg_state), 32'(IDLE));
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    in_valid = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || in_ready || dbg_state !== IDLE) bad++;
    end
    check("rstmid_blocked", 32'(bad), 32'd0);
    in_valid = 1'b0;
    load_kernel(49'({$urandom(), $urandom()}));
    send_window(49'({$urandom(), $urandom()}), 7'($urandom_range(0, 127)));
    wait_result(7);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bnn_window_sched.md
# bnn_window_sched

Sequencer for the 7×7 binary XNOR-popcount datapath.
- Holds a 49-bit binary weight kernel, loaded as seven 7-bit row beats.
- Accepts 49-bit binarised image windows over a valid/ready handshake and sweeps the kernel one row per cycle through a single shared 7-bit XNOR/popcount lane.
- Returns the raw match count, the signed ±1 dot product and an optional thresholded activation bit.
- Sits between the window line-buffer and the activation store of the BNN convolution pipeline.

## Interface
Parameters:
- K, 7, kernel side; kernel holds K*K bits.
- THRESH_W, 7, width of the signed threshold.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort to IDLE.
- w_valid  in  1  weight row beat valid.
- w_row  in  K  weight row bits, row 0 first.
- w_ready  out  1  weight beat accepted when w_valid && w_ready.
- in_valid  in  1  image window valid.
- in_img  in  K*K  window bits; row r occupies [r*K +: K].
- in_ready  out  1  window accepted when in_valid && in_ready.
- thresh  in  THRESH_W  signed activation threshold; sampled at window accept.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  result consumer ready.
- out_pop  out  6  XNOR match count, range 0..49.
- out_score  out  7  signed dot product, 2*out_pop − 49, range −49..49.
- out_act  out  1  activation bit, out_score >= thresh.

## Operation
States:
- IDLE: accepts weight beats or a window.
- CALC: one kernel row per edge.
- OUT: result presented, waiting for consumer.

Handshakes:
- w_ready = (state == IDLE).
- in_ready = (state == IDLE) && w_loaded && !w_valid. Weights win on a simultaneous w_valid/in_valid.

Weight load:
- Each accepted beat writes w_row into kernel row w_ptr.
- w_ptr counts 0..6 and wraps to 0.
- Accepting beat 6 sets w_loaded.
- Any accepted beat with w_ptr == 0 clears w_loaded. A reload blocks windows until all 7 rows have arrived.

Window accept:
- Register in_img and thresh.
- Clear the accumulator and set row = 0.
- Go to CALC.

CALC:
- Each edge: acc += popcount(~(img_row[row] ^ w_row[row])). This is 0..7 per row.
- row increments.
- Leaving row 6 goes to OUT.
- acc is unsigned 6-bit and cannot overflow (maximum 49).

OUT:
- out_* are registered and stable while out_valid is high.
- Score is computed in 7-bit signed arithmetic: score = {acc,1'b0} − 49.
- The handshake edge returns to IDLE; out_valid falls.

flush:
- Highest priority in every state: next state is IDLE, out_valid = 0, w_ptr = 0.
- Kernel contents and w_loaded are kept. A flush mid-load leaves w_loaded = 0 if the load was incomplete.

Reset:
- Sets state = IDLE.
- Sets w_ptr, row, acc, w_loaded and kernel to 0.
- Sets out_valid, out_pop, out_score and out_act to 0.
- Sets w_ready = 1 and in_ready = 0.

## Timing
- Window latency: out_valid rises after the 7th rising edge following the accept edge.
- Result handshake: earliest on the 8th edge after accept.
- Throughput with out_ready tied high: one window per 9 cycles (accept, 7 × CALC, 1 × OUT).
- out_valid back-pressure holds state indefinitely; no data is lost.
- Weight load: 7 consecutive cycles minimum. w_loaded is usable for in_ready in the cycle after beat 6.
- Reset deassertion is synchronised externally; there is no internal reset synchroniser.

## Configuration
BNN_THRESH_EN:
- Defined: out_act = (out_score >= thresh), registered with the result.
- Undefined: out_act is tied 0, thresh is ignored and no threshold register or comparator is built.
- The port list is identical either way.

## Structure
Package bnn_pkg holds:
- K, KK = K*K and POP_W = 6.
- The state enum {IDLE, CALC, OUT}.
- Score bias constant 49.

One sub-module, xnor_pop_row:
- Combinational K-bit XNOR followed by a 3-bit popcount.
- Instantiated once and time-shared across rows.

## Test plan
- Reset, load 7 rows of 7'h7F, send window all-ones → out_pop = 49, out_score = +49, out_valid 7 edges after accept.
- Weights all-ones, window all-zeros → out_pop = 0, out_score = −49, out_act = 0 with thresh = 0.
- Checkerboard weights, window = weights XOR row 3 inverted → out_pop = 42, out_score = 35; with thresh = 35, out_act = 1; with thresh = 36, out_act = 0 (macro on); out_act = 0 always (macro off).
- in_valid and w_valid asserted together in IDLE → weight beat taken, in_ready low; after 3 beats, in_ready stays 0 until beat 7 completes.
- out_ready held low 20 cycles → out_* stable, in_ready 0; release → one handshake, next window accepted the following cycle.
- flush during CALC row 4, and rst pulse mid-CALC → IDLE next cycle, out_valid never asserted. flush keeps the kernel (window accepted immediately); rst requires a reload.
